// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle MIPS-subset control FSM with memory wait states and exceptions.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   opcode, funct         : IR[31:26] / IR[5:0]
//   zero, overflow        : ALU flags
//   PCWrite..EQorNE       : single-bit datapath enables/selects
//   ALUOp, IorD, PCSrc,
//   RegDst, ALUSrcB,
//   MemtoReg              : multi-bit datapath selects
//   state_out             : current state code
module multicycle_ctrl_fsm #(
    parameter int unsigned MEM_WAIT    = 2,
    parameter logic [3:0]  SP_INIT_SEL = 4'd8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       overflow,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       MemRead_Write,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       ALUOutLoad,
    output logic       EPCWrite,
    output logic       RegALoad,
    output logic       RegBLoad,
    output logic       ALUSrcA,
    output logic       EQorNE,
    output logic [2:0] ALUOp,
    output logic [2:0] IorD,
    output logic [2:0] PCSrc,
    output logic [1:0] RegDst,
    output logic [1:0] ALUSrcB,
    output logic [3:0] MemtoReg,
    output logic [4:0] state_out
);

    localparam logic [4:0] S_RESET    = 5'd0;
    localparam logic [4:0] S_FETCH    = 5'd1;
    localparam logic [4:0] S_DECODE   = 5'd2;
    localparam logic [4:0] S_EXEC_R   = 5'd3;
    localparam logic [4:0] S_EXEC_I   = 5'd4;
    localparam logic [4:0] S_WB_R     = 5'd5;
    localparam logic [4:0] S_WB_I     = 5'd6;
    localparam logic [4:0] S_MEM_ADDR = 5'd7;
    localparam logic [4:0] S_MEM_RD   = 5'd8;
    localparam logic [4:0] S_WB_LW    = 5'd9;
    localparam logic [4:0] S_MEM_WR   = 5'd10;
    localparam logic [4:0] S_BRANCH   = 5'd11;
    localparam logic [4:0] S_JUMP     = 5'd12;
    localparam logic [4:0] S_EXC_EPC  = 5'd13;
    localparam logic [4:0] S_EXC_RD   = 5'd14;
    localparam logic [4:0] S_EXC_PC   = 5'd15;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;

    localparam logic [2:0] ALU_LOADA = 3'b000;
    localparam logic [2:0] ALU_ADD   = 3'b001;
    localparam logic [2:0] ALU_SUB   = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;

    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT - 1);

    logic [4:0] state;
    logic [4:0] state_nxt;
    logic [3:0] cnt;
    logic       cause_ovf;
    logic       cause_nxt;
    logic       wait_done;
    logic       funct_ok;
    logic       r_traps;

    // zero is consumed by the datapath's PC gating, not by the FSM.
    logic unused_zero;
    assign unused_zero = zero;

    assign wait_done = (cnt == WAIT_LAST);
    assign funct_ok  = (funct == FN_ADD) || (funct == FN_SUB) ||
                       (funct == FN_AND);
    // Logical and cannot overflow, so only add/sub may trap.
    assign r_traps   = overflow && (funct != FN_AND);
    assign state_out = state;

    always_comb begin
        state_nxt = state;
        cause_nxt = cause_ovf;
        case (state)
            S_RESET: state_nxt = S_FETCH;
            S_FETCH: begin
                if (wait_done) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE: state_nxt = funct_ok ? S_EXEC_R : S_EXC_EPC;
                    OP_ADDI:  state_nxt = S_EXEC_I;
                    OP_LW,
                    OP_SW:    state_nxt = S_MEM_ADDR;
                    OP_BEQ,
                    OP_BNE:   state_nxt = S_BRANCH;
                    OP_J:     state_nxt = S_JUMP;
                    default:  state_nxt = S_EXC_EPC;
                endcase
                cause_nxt = 1'b0;
            end
            S_EXEC_R: begin
                state_nxt = r_traps ? S_EXC_EPC : S_WB_R;
                cause_nxt = 1'b1;
            end
            S_EXEC_I: begin
                state_nxt = overflow ? S_EXC_EPC : S_WB_I;
                cause_nxt = 1'b1;
            end
            S_WB_R:     state_nxt = S_FETCH;
            S_WB_I:     state_nxt = S_FETCH;
            S_MEM_ADDR: begin
                state_nxt = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                if (wait_done) state_nxt = S_WB_LW;
            end
            S_WB_LW: state_nxt = S_FETCH;
            S_MEM_WR: begin
                if (wait_done) state_nxt = S_FETCH;
            end
            S_BRANCH:  state_nxt = S_FETCH;
            S_JUMP:    state_nxt = S_FETCH;
            S_EXC_EPC: state_nxt = S_EXC_RD;
            S_EXC_RD: begin
                if (wait_done) state_nxt = S_EXC_PC;
            end
            S_EXC_PC: state_nxt = S_FETCH;
            default:  state_nxt = S_RESET;
        endcase
    end

    // Cause only moves when actually entering EXC_EPC, so it stays
    // stable through EXC_RD.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_RESET;
            cnt       <= 4'd0;
            cause_ovf <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                cnt <= 4'd0;
            end else begin
                cnt <= cnt + 4'd1;
            end
            if (state_nxt == S_EXC_EPC) begin
                cause_ovf <= cause_nxt;
            end
        end
    end

    always_comb begin
        PCWrite       = 1'b0;
        PCWriteCond   = 1'b0;
        MemRead_Write = 1'b0;
        IRWrite       = 1'b0;
        RegWrite      = 1'b0;
        ALUOutLoad    = 1'b0;
        EPCWrite      = 1'b0;
        RegALoad      = 1'b0;
        RegBLoad      = 1'b0;
        ALUSrcA       = 1'b0;
        EQorNE        = 1'b0;
        ALUOp         = ALU_LOADA;
        IorD          = 3'd0;
        PCSrc         = 3'd0;
        RegDst        = 2'd0;
        ALUSrcB       = 2'd0;
        MemtoReg      = 4'd0;
        case (state)
            S_RESET: begin
                RegWrite = 1'b1;
                RegDst   = 2'd2;
                MemtoReg = SP_INIT_SEL;
            end
            S_FETCH: begin
                ALUSrcB = 2'd1;
                ALUOp   = ALU_ADD;
                // PC+4 and IR capture only once memory data is valid.
                PCWrite = wait_done;
                IRWrite = wait_done;
            end
            S_DECODE: begin
                RegALoad   = 1'b1;
                RegBLoad   = 1'b1;
                ALUSrcB    = 2'd3;
                ALUOp      = ALU_ADD;
                ALUOutLoad = 1'b1;
            end
            S_EXEC_R: begin
                ALUSrcA    = 1'b1;
                ALUOutLoad = 1'b1;
                case (funct)
                    FN_SUB:  ALUOp = ALU_SUB;
                    FN_AND:  ALUOp = ALU_AND;
                    default: ALUOp = ALU_ADD;
                endcase
            end
            S_EXEC_I,
            S_MEM_ADDR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'd2;
                ALUOp      = ALU_ADD;
                ALUOutLoad = 1'b1;
            end
            S_WB_R: begin
                RegWrite = 1'b1;
                RegDst   = 2'd1;
            end
            S_WB_I: RegWrite = 1'b1;
            S_MEM_RD: IorD = 3'd1;
            S_WB_LW: begin
                RegWrite = 1'b1;
                MemtoReg = 4'd1;
            end
            S_MEM_WR: begin
                IorD          = 3'd1;
                MemRead_Write = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALU_SUB;
                PCWriteCond = 1'b1;
                PCSrc       = 3'd1;
                EQorNE      = (opcode == OP_BNE);
            end
            S_JUMP: begin
                PCWrite = 1'b1;
                PCSrc   = 3'd2;
            end
            S_EXC_EPC: begin
                // PC already advanced in FETCH; EPC gets PC-4.
                ALUSrcB  = 2'd1;
                ALUOp    = ALU_SUB;
                EPCWrite = 1'b1;
            end
            S_EXC_RD: IorD = cause_ovf ? 3'd4 : 3'd3;
            S_EXC_PC: begin
                PCWrite = 1'b1;
                PCSrc   = 3'd4;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm: expected per-cycle
// control vectors are queued per instruction and popped each cycle.
module tb_multicycle_ctrl_fsm;

    localparam int M = 3;

    localparam logic [4:0] S_RESET    = 5'd0;
    localparam logic [4:0] S_FETCH    = 5'd1;
    localparam logic [4:0] S_DECODE   = 5'd2;
    localparam logic [4:0] S_EXEC_R   = 5'd3;
    localparam logic [4:0] S_EXEC_I   = 5'd4;
    localparam logic [4:0] S_WB_R     = 5'd5;
    localparam logic [4:0] S_WB_I     = 5'd6;
    localparam logic [4:0] S_MEM_ADDR = 5'd7;
    localparam logic [4:0] S_MEM_RD   = 5'd8;
    localparam logic [4:0] S_WB_LW    = 5'd9;
    localparam logic [4:0] S_MEM_WR   = 5'd10;
    localparam logic [4:0] S_BRANCH   = 5'd11;
    localparam logic [4:0] S_JUMP     = 5'd12;
    localparam logic [4:0] S_EXC_EPC  = 5'd13;
    localparam logic [4:0] S_EXC_RD   = 5'd14;
    localparam logic [4:0] S_EXC_PC   = 5'd15;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       mem_wr;
        logic       ir_write;
        logic       reg_write;
        logic       alu_out_load;
        logic       epc_write;
        logic       rega;
        logic       regb;
        logic       alu_src_a;
        logic       eq_ne;
        logic [2:0] alu_op;
        logic [2:0] iord;
        logic [2:0] pc_src;
        logic [1:0] reg_dst;
        logic [1:0] alu_src_b;
        logic [3:0] mem_to_reg;
        logic [4:0] st;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       overflow;
    logic       PCWrite, PCWriteCond, MemRead_Write, IRWrite, RegWrite;
    logic       ALUOutLoad, EPCWrite, RegALoad, RegBLoad, ALUSrcA, EQorNE;
    logic [2:0] ALUOp, IorD, PCSrc;
    logic [1:0] RegDst, ALUSrcB;
    logic [3:0] MemtoReg;
    logic [4:0] state_out;

    multicycle_ctrl_fsm #(.MEM_WAIT(M), .SP_INIT_SEL(4'd8)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
        .zero(zero), .overflow(overflow),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
        .MemRead_Write(MemRead_Write), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .ALUOutLoad(ALUOutLoad),
        .EPCWrite(EPCWrite), .RegALoad(RegALoad), .RegBLoad(RegBLoad),
        .ALUSrcA(ALUSrcA), .EQorNE(EQorNE), .ALUOp(ALUOp), .IorD(IorD),
        .PCSrc(PCSrc), .RegDst(RegDst), .ALUSrcB(ALUSrcB),
        .MemtoReg(MemtoReg), .state_out(state_out)
    );

    always #5 clk = ~clk;

    obs_t obs;
    assign obs = {PCWrite, PCWriteCond, MemRead_Write, IRWrite, RegWrite,
                  ALUOutLoad, EPCWrite, RegALoad, RegBLoad, ALUSrcA, EQorNE,
                  ALUOp, IorD, PCSrc, RegDst, ALUSrcB, MemtoReg, state_out};

    obs_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input obs_t got, input obs_t want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic drain(input string tag);
        obs_t e;
        int   i;
        i = 0;
        while (q.size() > 0) begin
            e = q.pop_front();
            @(posedge clk);
            #1;
            chk($sformatf("%s[%0d]", tag, i), obs, e);
            i++;
        end
    endtask

    task automatic set_in(input logic [5:0] op, input logic [5:0] fn,
                          input logic ov);
        opcode   = op;
        funct    = fn;
        overflow = ov;
    endtask

    function automatic obs_t blank(input logic [4:0] st);
        obs_t e;
        e    = '0;
        e.st = st;
        return e;
    endfunction

    task automatic p_reset();
        obs_t e;
        e            = blank(S_RESET);
        e.reg_write  = 1'b1;
        e.reg_dst    = 2'd2;
        e.mem_to_reg = 4'd8;
        q.push_back(e);
    endtask

    task automatic p_fetch_decode();
        obs_t e;
        for (int i = 0; i < M; i++) begin
            e           = blank(S_FETCH);
            e.alu_src_b = 2'd1;
            e.alu_op    = 3'b001;
            if (i == M - 1) begin
                e.pc_write = 1'b1;
                e.ir_write = 1'b1;
            end
            q.push_back(e);
        end
        e              = blank(S_DECODE);
        e.rega         = 1'b1;
        e.regb         = 1'b1;
        e.alu_src_b    = 2'd3;
        e.alu_op       = 3'b001;
        e.alu_out_load = 1'b1;
        q.push_back(e);
    endtask

    task automatic p_exc(input logic ovf);
        obs_t e;
        e           = blank(S_EXC_EPC);
        e.alu_src_b = 2'd1;
        e.alu_op    = 3'b010;
        e.epc_write = 1'b1;
        q.push_back(e);
        for (int i = 0; i < M; i++) begin
            e      = blank(S_EXC_RD);
            e.iord = ovf ? 3'd4 : 3'd3;
            q.push_back(e);
        end
        e          = blank(S_EXC_PC);
        e.pc_write = 1'b1;
        e.pc_src   = 3'd4;
        q.push_back(e);
    endtask

    task automatic p_imm_addr(input logic [4:0] st);
        obs_t e;
        e              = blank(st);
        e.alu_src_a    = 1'b1;
        e.alu_src_b    = 2'd2;
        e.alu_op       = 3'b001;
        e.alu_out_load = 1'b1;
        q.push_back(e);
    endtask

    task automatic rtype(input logic [5:0] fn, input logic [2:0] aop,
                         input logic ov, input logic trap);
        obs_t e;
        set_in(6'h00, fn, ov);
        p_fetch_decode();
        e              = blank(S_EXEC_R);
        e.alu_src_a    = 1'b1;
        e.alu_op       = aop;
        e.alu_out_load = 1'b1;
        q.push_back(e);
        if (trap) begin
            p_exc(1'b1);
        end else begin
            e           = blank(S_WB_R);
            e.reg_write = 1'b1;
            e.reg_dst   = 2'd1;
            q.push_back(e);
        end
        drain($sformatf("rtype_%h_ov%0d", fn, ov));
    endtask

    task automatic addi(input logic ov);
        obs_t e;
        set_in(6'h08, 6'h00, ov);
        p_fetch_decode();
        p_imm_addr(S_EXEC_I);
        if (ov) begin
            p_exc(1'b1);
        end else begin
            e           = blank(S_WB_I);
            e.reg_write = 1'b1;
            q.push_back(e);
        end
        drain($sformatf("addi_ov%0d", ov));
    endtask

    task automatic bad_op(input logic [5:0] op, input logic [5:0] fn);
        set_in(op, fn, 1'b1);
        p_fetch_decode();
        p_exc(1'b0);
        drain($sformatf("badop_%h_%h", op, fn));
    endtask

    task automatic mem_op(input logic is_lw);
        obs_t e;
        set_in(is_lw ? 6'h23 : 6'h2B, 6'h00, 1'b1);
        p_fetch_decode();
        p_imm_addr(S_MEM_ADDR);
        for (int i = 0; i < M; i++) begin
            e        = blank(is_lw ? S_MEM_RD : S_MEM_WR);
            e.iord   = 3'd1;
            e.mem_wr = !is_lw;
            q.push_back(e);
        end
        if (is_lw) begin
            e            = blank(S_WB_LW);
            e.reg_write  = 1'b1;
            e.mem_to_reg = 4'd1;
            q.push_back(e);
        end
        drain(is_lw ? "lw" : "sw");
    endtask

    task automatic branch(input logic bne);
        obs_t e;
        set_in(bne ? 6'h05 : 6'h04, 6'h00, 1'b0);
        p_fetch_decode();
        e               = blank(S_BRANCH);
        e.alu_src_a     = 1'b1;
        e.alu_op        = 3'b010;
        e.pc_write_cond = 1'b1;
        e.pc_src        = 3'd1;
        e.eq_ne         = bne;
        q.push_back(e);
        drain(bne ? "bne" : "beq");
    endtask

    task automatic jump();
        obs_t e;
        set_in(6'h02, 6'h00, 1'b0);
        p_fetch_decode();
        e          = blank(S_JUMP);
        e.pc_write = 1'b1;
        e.pc_src   = 3'd2;
        q.push_back(e);
        drain("j");
    endtask

    task automatic lw_reset_mid();
        obs_t e;
        set_in(6'h23, 6'h00, 1'b0);
        p_fetch_decode();
        p_imm_addr(S_MEM_ADDR);
        e      = blank(S_MEM_RD);
        e.iord = 3'd1;
        q.push_back(e);
        drain("lw_pre_rst");
        rst = 1'b1;
        p_reset();
        drain("lw_mid_rst");
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        opcode   = 6'h00;
        funct    = 6'h00;
        zero     = 1'b0;
        overflow = 1'b0;
        for (int i = 0; i < 3; i++) p_reset();
        drain("reset");
        rst = 1'b0;
        rtype(6'h20, 3'b001, 1'b0, 1'b0);
        rtype(6'h22, 3'b010, 1'b0, 1'b0);
        rtype(6'h24, 3'b011, 1'b1, 1'b0);
        rtype(6'h20, 3'b001, 1'b1, 1'b1);
        rtype(6'h22, 3'b010, 1'b1, 1'b1);
        addi(1'b0);
        addi(1'b1);
        bad_op(6'h3F, 6'h20);
        bad_op(6'h00, 6'h21);
        mem_op(1'b1);
        mem_op(1'b0);
        zero = 1'b1;
        branch(1'b0);
        branch(1'b1);
        jump();
        lw_reset_mid();
        rtype(6'h20, 3'b001, 1'b0, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Parametrised multicycle MIPS-subset control unit. It drives every mux-select and load-enable of the datapath: memory, IR, register bank, ALU, ALUOut, A/B, EPC and PC.
- Generalises the fixed-latency controller in two ways:
  - Memory wait states are configurable.
  - Opcode and overflow exceptions are handled through EPC and a vector fetch.
- Sits beside the datapath top; consumes IR opcode/funct and ALU flags.

Parameters:
MEM_WAIT, 2, cycles a memory read or write is held before data is valid (1..15)
SP_INIT_SEL, 4'd8, MemtoReg select that routes the stack-pointer constant 227 during reset

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
opcode  input  6  IR[31:26]
funct  input  6  IR[5:0]
zero  input  1  ALU zero flag
overflow  input  1  ALU overflow flag
PCWrite, PCWriteCond, MemRead_Write, IRWrite, RegWrite, ALUOutLoad, EPCWrite, RegALoad, RegBLoad, ALUSrcA, EQorNE  output  1 each  datapath enables/selects (MemRead_Write: 1=write)
ALUOp  output  3  000 loadA, 001 add, 010 sub, 011 and
IorD  output  3  0 PC, 1 ALUOut, 3 vector 253 (opcode exc), 4 vector 254 (overflow exc)
PCSrc  output  3  0 ALU result, 1 ALUOut, 2 jump target, 4 exception byte from memory
RegDst  output  2  0 rt, 1 rd, 2 reg 29
ALUSrcB  output  2  0 B, 1 const 4, 2 sign-ext imm, 3 sign-ext imm<<2
MemtoReg  output  4  0 ALUOut, 1 MDR, SP_INIT_SEL constant 227
state_out  output  5  current state code, for debug/verification

Behaviour:
- States: RESET, FETCH, DECODE, EXEC_R, EXEC_I, WB_R, WB_I, MEM_ADDR, MEM_RD, WB_LW, MEM_WR, BRANCH, JUMP, EXC_EPC, EXC_RD, EXC_PC.
- Internal wait counter: 4 bits, cleared on every state entry.
- All outputs are 0 in every state except where listed.
- rst=1, at any time (including mid-instruction or mid-wait): next state RESET, counter cleared.
- RESET (1 cycle): RegWrite=1, RegDst=2, MemtoReg=SP_INIT_SEL. Then FETCH.
- FETCH:
  - Held for MEM_WAIT cycles: IorD=0, MemRead_Write=0, ALUSrcA=0, ALUSrcB=1, ALUOp=add.
  - Last cycle additionally asserts PCWrite (PCSrc=0) and IRWrite. Then DECODE.
- DECODE (1 cycle): RegALoad=RegBLoad=1, ALUSrcA=0, ALUSrcB=3, ALUOp=add, ALUOutLoad=1. Dispatch on opcode:
  - 0x00 with funct 0x20/0x22/0x24 -> EXEC_R
  - 0x08 -> EXEC_I
  - 0x23, 0x2B -> MEM_ADDR
  - 0x04, 0x05 -> BRANCH
  - 0x02 -> JUMP
  - anything else, including an unknown funct -> EXC_EPC (cause opcode)
- EXEC_R:
  - ALUSrcA=1, ALUSrcB=0, ALUOp from funct (add/sub/and), ALUOutLoad=1.
  - overflow=1 on add/sub -> EXC_EPC (cause overflow), else WB_R.
  - and never traps.
- WB_R: RegWrite=1, RegDst=1, MemtoReg=0. Then FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=2, ALUOp=add, ALUOutLoad=1. overflow -> EXC_EPC, else WB_I.
- WB_I: RegWrite=1, RegDst=0, MemtoReg=0. Then FETCH.
- MEM_ADDR: as EXEC_I but no overflow trap. Then MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: IorD=1, read, MEM_WAIT cycles. Then WB_LW.
- WB_LW: RegWrite=1, RegDst=0, MemtoReg=1. Then FETCH.
- MEM_WR: IorD=1, MemRead_Write=1 for MEM_WAIT cycles. Then FETCH.
- BRANCH (1 cycle):
  - ALUSrcA=1, ALUSrcB=0, ALUOp=sub, PCWriteCond=1, PCSrc=1.
  - EQorNE=0 for beq, 1 for bne; the datapath gates PC with zero / ~zero.
  - Then FETCH.
- JUMP: PCWrite=1, PCSrc=2. Then FETCH.
- EXC_EPC: ALUSrcA=0, ALUSrcB=1, ALUOp=sub, EPCWrite=1, so EPC <= PC-4. Then EXC_RD.
- EXC_RD: IorD=3 (opcode cause) or 4 (overflow cause), held MEM_WAIT cycles. Cause is latched on entry to EXC_EPC. Then EXC_PC.
- EXC_PC: PCWrite=1, PCSrc=4. Then FETCH.
- Cycle counts (M=MEM_WAIT):
  - R/addi: M+3
  - lw: 2M+3
  - sw: 2M+2
  - beq/bne/j: M+2
  - exception path after detection: M+2
- No write is ever issued to a register after overflow: RegWrite stays 0 in the trapping instruction.

Test Plan:
- rst held 3 cycles then released -> every cycle of reset shows state RESET; first post-reset cycle RegWrite=1, RegDst=2, MemtoReg=8; FETCH follows; IRWrite pulses exactly at cycle M of FETCH (MEM_WAIT=2 and MEM_WAIT=5 builds).
- opcode=0, funct=0x20, overflow=0 -> WB_R asserts RegWrite, RegDst=1 exactly 5 cycles after fetch start (M=2); next FETCH follows.
- addi with overflow=1 in EXEC_I -> EXC_EPC with EPCWrite=1 and ALUOp=010; EXC_RD IorD=4 for M cycles; EXC_PC PCWrite=1, PCSrc=4; RegWrite never 1.
- opcode=0x3F -> DECODE goes to EXC_EPC; EXC_RD shows IorD=3.
- lw (0x23) with M=3 -> MEM_RD holds IorD=1, MemRead_Write=0 for 3 cycles; WB_LW MemtoReg=1; total 9 cycles. sw (0x2B) -> MemRead_Write=1 for 3 cycles, no RegWrite.
- beq/bne -> PCWriteCond=1, PCSrc=1, EQorNE 0/1. rst asserted in mid MEM_RD wait -> next state RESET, no WB_LW.
